// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory arbiter slice.
//   arb_state_t : arbiter FSM states (IDLE, WRITE, FILL, DONE)
//   TGT_I/TGT_D : fill target select (which cache receives the block)
//   blk_off_w() : word-offset width for a given block size
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    FILL,
    DONE
  } arb_state_t;

  localparam logic TGT_I = 1'b0;
  localparam logic TGT_D = 1'b1;

  function automatic int unsigned blk_off_w(input int unsigned blk_words);
    return $clog2(blk_words);
  endfunction

endpackage

// File: rtl/blk_fill_seq.sv
// Block fill sequencer: latches the block base, issues BLK_WORDS pipelined
// read addresses back to back, counts returned words and flags the last one.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   start       clear both counters and latch base from miss_addr
//   active      arbiter is in FILL
//   miss_addr   byte address of the granted miss
//   mem_valid   memory read data valid
//   issue       a read address is presented this cycle
//   rd_addr     read byte address (base + 2*iss_cnt)
//   rcv         a word is returned this cycle
//   rcv_word    word index of the returned word
//   last        returned word is the final word of the block
module blk_fill_seq
  import mem_arb_pkg::*;
#(
  parameter  int unsigned ADDR_W    = 16,
  parameter  int unsigned BLK_WORDS = 8,
  localparam int unsigned BLK_OFF_W = blk_off_w(BLK_WORDS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 active,
  input  logic [ADDR_W-1:0]    miss_addr,
  input  logic                 mem_valid,
  output logic                 issue,
  output logic [ADDR_W-1:0]    rd_addr,
  output logic                 rcv,
  output logic [BLK_OFF_W-1:0] rcv_word,
  output logic                 last
);

  localparam int unsigned       CNT_W    = BLK_OFF_W + 1;
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(BLK_WORDS);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BLK_WORDS - 1);
  // Byte-offset bits inside a block (word offset plus the byte-in-word bit).
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << CNT_W) - 1);

  logic [CNT_W-1:0]  iss_cnt;
  logic [CNT_W-1:0]  rcv_cnt;
  logic [ADDR_W-1:0] base;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base    <= '0;
      iss_cnt <= '0;
      rcv_cnt <= '0;
    end else if (start) begin
      base    <= miss_addr & ~OFF_MASK;
      iss_cnt <= '0;
      rcv_cnt <= '0;
    end else if (active) begin
      if (issue) iss_cnt <= iss_cnt + CNT_W'(1);
      if (rcv)   rcv_cnt <= rcv_cnt + CNT_W'(1);
    end
  end

  assign issue    = active && (iss_cnt < CNT_FULL);
  assign rcv      = active && mem_valid;
  assign rcv_word = rcv_cnt[BLK_OFF_W-1:0];
  assign last     = rcv && (rcv_cnt == CNT_LAST);
  // Base has the in-block bits cleared, so the add never carries out of the block.
  assign rd_addr  = base + {{(ADDR_W-CNT_W-1){1'b0}}, iss_cnt, 1'b0};

endmodule

// File: rtl/mem_arbiter_ctrl.sv
// Arbiter for one single-ported unified memory shared by I-cache fills,
// D-cache fills and D-side write-through stores. Stores win; misses are
// fixed D>I, or round-robin when MEM_ARB_RR_EN is defined.
// Ports:
//   clk, rst_n                    clock / async active-low reset
//   i_miss_req, i_miss_addr       I-cache miss (held until i_fill_done)
//   d_miss_req, d_miss_addr       D-cache miss (held until d_fill_done)
//   d_wr_req, d_wr_addr, d_wr_data store request (held until d_wr_ack)
//   mem_en, mem_wr, mem_addr, mem_wdata  memory command
//   mem_rdata, mem_valid          memory read return
//   fill_data, fill_word          returned word and its index in the block
//   i_fill_we, d_fill_we          cache array write enables
//   i_fill_done, d_fill_done      last-word pulses
//   d_wr_ack                      store issued pulse
//   busy                          arbiter not idle
// Build option: MEM_ARB_RR_EN enables round-robin between I and D misses.
module mem_arbiter_ctrl
  import mem_arb_pkg::*;
#(
  parameter  int unsigned ADDR_W    = 16,
  parameter  int unsigned DATA_W    = 16,
  parameter  int unsigned BLK_WORDS = 8,
  parameter  int unsigned MEM_LAT   = 4,
  localparam int unsigned BLK_OFF_W = blk_off_w(BLK_WORDS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_miss_req,
  input  logic [ADDR_W-1:0]    i_miss_addr,
  input  logic                 d_miss_req,
  input  logic [ADDR_W-1:0]    d_miss_addr,
  input  logic                 d_wr_req,
  input  logic [ADDR_W-1:0]    d_wr_addr,
  input  logic [DATA_W-1:0]    d_wr_data,
  output logic                 mem_en,
  output logic                 mem_wr,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata,
  input  logic                 mem_valid,
  output logic [DATA_W-1:0]    fill_data,
  output logic [BLK_OFF_W-1:0] fill_word,
  output logic                 i_fill_we,
  output logic                 d_fill_we,
  output logic                 i_fill_done,
  output logic                 d_fill_done,
  output logic                 d_wr_ack,
  output logic                 busy
);

  // The arbiter only reacts to mem_valid, so any latency >= 1 works unchanged.
  if (MEM_LAT < 1) begin : g_bad_lat
    $error("mem_arbiter_ctrl: MEM_LAT must be >= 1");
  end

  arb_state_t state, state_nx;
  logic       tgt, tgt_nx;
  logic       start;
  logic [ADDR_W-1:0] sel_addr;

  logic                 issue, rcv, last;
  logic [ADDR_W-1:0]    rd_addr;
  logic [BLK_OFF_W-1:0] rcv_word;

`ifdef MEM_ARB_RR_EN
  logic rr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    rr_ptr <= TGT_D;
    else if (state == FILL && last) rr_ptr <= ~tgt;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tgt   <= TGT_I;
    end else begin
      state <= state_nx;
      tgt   <= tgt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    tgt_nx   = tgt;
    start    = 1'b0;
    sel_addr = d_miss_addr;
    unique case (state)
      IDLE: begin
        if (d_wr_req) begin
          state_nx = WRITE;
        end else if (d_miss_req || i_miss_req) begin
          state_nx = FILL;
          start    = 1'b1;
`ifdef MEM_ARB_RR_EN
          if (d_miss_req && i_miss_req) tgt_nx = rr_ptr;
          else                          tgt_nx = d_miss_req ? TGT_D : TGT_I;
`else
          tgt_nx = d_miss_req ? TGT_D : TGT_I;
`endif
          sel_addr = (tgt_nx == TGT_D) ? d_miss_addr : i_miss_addr;
        end
      end
      WRITE:   state_nx = DONE;
      FILL:    if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    fill_data   = '0;
    fill_word   = '0;
    i_fill_we   = 1'b0;
    d_fill_we   = 1'b0;
    i_fill_done = 1'b0;
    d_fill_done = 1'b0;
    d_wr_ack    = 1'b0;
    unique case (state)
      WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = d_wr_addr;
        mem_wdata = d_wr_data;
        d_wr_ack  = 1'b1;
      end
      FILL: begin
        if (issue) begin
          mem_en   = 1'b1;
          mem_addr = rd_addr;
        end
        if (rcv) begin
          fill_data   = mem_rdata;
          fill_word   = rcv_word;
          i_fill_we   = (tgt == TGT_I);
          d_fill_we   = (tgt == TGT_D);
          i_fill_done = last && (tgt == TGT_I);
          d_fill_done = last && (tgt == TGT_D);
        end
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

  blk_fill_seq #(
    .ADDR_W   (ADDR_W),
    .BLK_WORDS(BLK_WORDS)
  ) u_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .active   (state == FILL),
    .miss_addr(sel_addr),
    .mem_valid(mem_valid),
    .issue    (issue),
    .rd_addr  (rd_addr),
    .rcv      (rcv),
    .rcv_word (rcv_word),
    .last     (last)
  );

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Bench for mem_arbiter_ctrl: transaction-level model checked every cycle,
// a latency-MEM_LAT memory responder, and directed scenarios with literal checks.
module tb_mem_arbiter_ctrl;

  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned BLK_WORDS = 8;
  localparam int unsigned MEM_LAT   = 4;
  localparam int unsigned BLK_OFF_W = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_miss_req = 1'b0, d_miss_req = 1'b0, d_wr_req = 1'b0;
  logic [ADDR_W-1:0] i_miss_addr = '0, d_miss_addr = '0, d_wr_addr = '0;
  logic [DATA_W-1:0] d_wr_data = '0;
  logic mem_en, mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, fill_data;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic mem_valid = 1'b0;
  logic [BLK_OFF_W-1:0] fill_word;
  logic i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_ack, busy;

  always #5 clk = ~clk;

  mem_arbiter_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BLK_WORDS(BLK_WORDS), .MEM_LAT(MEM_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_miss_req(i_miss_req), .i_miss_addr(i_miss_addr),
    .d_miss_req(d_miss_req), .d_miss_addr(d_miss_addr),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .fill_data(fill_data), .fill_word(fill_word),
    .i_fill_we(i_fill_we), .d_fill_we(d_fill_we),
    .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
    .d_wr_ack(d_wr_ack), .busy(busy)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- memory responder ----------------
  typedef struct { int due; logic [DATA_W-1:0] data; } rd_t;
  rd_t rq[$];
  bit drop_i = 0, drop_d = 0, drop_w = 0, hold_mode = 0;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      mem_valid = 1'b0;
      mem_rdata = 16'hDEAD;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        mem_valid = 1'b1;
        mem_rdata = rq[0].data;
        void'(rq.pop_front());
      end
      if (drop_i) begin i_miss_req = 1'b0; drop_i = 0; end
      if (drop_d) begin d_miss_req = 1'b0; drop_d = 0; end
      if (drop_w) begin d_wr_req = 1'b0; drop_w = 0; end
    end
  end

  // ---------------- logs ----------------
  logic [ADDR_W-1:0] rd_log[$];
  int rd_cyc[$];
  logic [ADDR_W-1:0] wr_addr_log[$];
  logic [DATA_W-1:0] wr_data_log[$];
  int wr_cyc[$];
  int i_done_q[$], d_done_q[$];
  bit order_q[$];           // 1 = D fill, 0 = I fill (logged on word 0)
  logic [DATA_W-1:0] first_word_q[$];
  int d_we_cnt = 0;

  // ---------------- transaction model + compare ----------------
  bit m_in = 0, m_wr = 0, m_tgt_d = 0, m_rr_d = 1;
  int m_start = 0, m_rx = 0, m_quiet = 0;
  logic [ADDR_W-1:0] m_base = '0;

  always @(negedge clk) begin
    logic e_en, e_wr, e_iwe, e_dwe, e_idn, e_ddn, e_ack, e_busy;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata, e_fdata;
    logic [BLK_OFF_W-1:0] e_fword;
    int k;
    e_en = 0; e_wr = 0; e_iwe = 0; e_dwe = 0; e_idn = 0; e_ddn = 0; e_ack = 0; e_busy = 0;
    e_addr = '0; e_wdata = '0; e_fdata = '0; e_fword = '0;

    // memory + logs observe the DUT
    if (mem_en && !mem_wr) begin
      rq.push_back('{due: cyc + int'(MEM_LAT), data: mem_addr ^ 16'h5A3C});
      rd_log.push_back(mem_addr);
      rd_cyc.push_back(cyc);
    end
    if (mem_en && mem_wr) begin
      wr_addr_log.push_back(mem_addr);
      wr_data_log.push_back(mem_wdata);
      wr_cyc.push_back(cyc);
    end
    if ((i_fill_we || d_fill_we) && fill_word == 0) begin
      order_q.push_back(d_fill_we);
      first_word_q.push_back(fill_data);
    end
    if (d_fill_we) d_we_cnt++;
    if (i_fill_done) begin i_done_q.push_back(cyc); if (!hold_mode) drop_i = 1; end
    if (d_fill_done) begin d_done_q.push_back(cyc); if (!hold_mode) drop_d = 1; end
    if (d_wr_ack) drop_w = 1;

    if (!rst_n) begin
      m_in = 0; m_quiet = 0; m_rr_d = 1;
    end else begin
      e_busy = m_in || (cyc < m_quiet);
      if (m_in) begin
        if (m_wr) begin
          e_en = 1; e_wr = 1; e_addr = d_wr_addr; e_wdata = d_wr_data; e_ack = 1;
          m_in = 0; m_quiet = cyc + 2;
        end else begin
          k = cyc - m_start;
          if (k >= 0 && k < int'(BLK_WORDS)) begin
            e_en = 1;
            e_addr = m_base + ADDR_W'(2 * k);
          end
          if (mem_valid) begin
            e_fdata = mem_rdata;
            e_fword = BLK_OFF_W'(m_rx);
            e_dwe = m_tgt_d;
            e_iwe = !m_tgt_d;
            if (m_rx == int'(BLK_WORDS) - 1) begin
              e_ddn = m_tgt_d;
              e_idn = !m_tgt_d;
              m_in = 0;
              m_quiet = cyc + 2;
              m_rr_d = !m_tgt_d;
            end
            m_rx++;
          end
        end
      end else if (cyc >= m_quiet) begin
        if (d_wr_req) begin
          m_in = 1; m_wr = 1;
        end else if (d_miss_req || i_miss_req) begin
          m_in = 1; m_wr = 0; m_rx = 0; m_start = cyc + 1;
`ifdef MEM_ARB_RR_EN
          m_tgt_d = (d_miss_req && i_miss_req) ? m_rr_d : d_miss_req;
`else
          m_tgt_d = d_miss_req;
`endif
          m_base = (m_tgt_d ? d_miss_addr : i_miss_addr) & 16'hFFF0;
        end
      end
    end

    if (cyc >= 1) begin
      chk("mem_en", 32'(mem_en), 32'(e_en));
      chk("mem_wr", 32'(mem_wr), 32'(e_wr));
      chk("mem_addr", 32'(mem_addr), 32'(e_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
      chk("fill_data", 32'(fill_data), 32'(e_fdata));
      chk("fill_word", 32'(fill_word), 32'(e_fword));
      chk("i_fill_we", 32'(i_fill_we), 32'(e_iwe));
      chk("d_fill_we", 32'(d_fill_we), 32'(e_dwe));
      chk("i_fill_done", 32'(i_fill_done), 32'(e_idn));
      chk("d_fill_done", 32'(d_fill_done), 32'(e_ddn));
      chk("d_wr_ack", 32'(d_wr_ack), 32'(e_ack));
      chk("busy", 32'(busy), 32'(e_busy));
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    rd_log.delete(); rd_cyc.delete();
    wr_addr_log.delete(); wr_data_log.delete(); wr_cyc.delete();
    i_done_q.delete(); d_done_q.delete(); order_q.delete(); first_word_q.delete();
    d_we_cnt = 0;
  endtask

  task automatic wait_quiet(string name, int budget);
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(!i_miss_req && !d_miss_req && !d_wr_req && !busy && rq.size() == 0)
               && n < budget);
    chk({name, "_quiet_timeout"}, 32'(n >= budget), 32'd0);
  endtask

  int req_cyc;
  int n;

  initial begin
    // reset
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("reset_outputs",
        32'({mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word, i_fill_we,
             d_fill_we, i_fill_done, d_fill_done, d_wr_ack, busy} != 0), 32'd0);
    step();
    rst_n = 1'b1;
    repeat (2) step();

    // 1: lone I miss
    clear_logs();
    i_miss_addr = 16'h1234; i_miss_req = 1'b1; req_cyc = cyc;
    wait_quiet("s1", 60);
    chk("s1_done_count", 32'(i_done_q.size()), 32'd1);
    if (i_done_q.size() == 1) chk("s1_latency", 32'(i_done_q[0] - req_cyc), 32'd12);
    chk("s1_reads", 32'(rd_log.size()), 32'd8);
    if (rd_log.size() == 8) begin
      chk("s1_first_rd", 32'(rd_log[0]), 32'h1230);
      chk("s1_last_rd", 32'(rd_log[7]), 32'h123E);
    end
    if (first_word_q.size() == 1) chk("s1_word0_data", 32'(first_word_q[0]), 32'h1230 ^ 32'h5A3C);

    // 2: simultaneous I and D miss
    step(); clear_logs();
    d_miss_addr = 16'h0040; i_miss_addr = 16'h0200;
    d_miss_req = 1'b1; i_miss_req = 1'b1;
    wait_quiet("s2", 100);
    chk("s2_fills", 32'(order_q.size()), 32'd2);
    if (order_q.size() == 2) begin
      chk("s2_first_is_d", 32'(order_q[0]), 32'd1);
      chk("s2_second_is_i", 32'(order_q[1]), 32'd0);
    end
    if (rd_log.size() == 16 && d_done_q.size() == 1) begin
      chk("s2_d_base", 32'(rd_log[0]), 32'h0040);
      chk("s2_i_base", 32'(rd_log[8]), 32'h0200);
      chk("s2_no_overlap", 32'(rd_cyc[8] - d_done_q[0]), 32'd3);
    end else chk("s2_logs", 32'(rd_log.size()), 32'd16);

    // 3: store and I miss arrive during a D fill
    step(); clear_logs();
    d_miss_addr = 16'h0600; d_miss_req = 1'b1;
    repeat (3) step();
    d_wr_addr = 16'h0100; d_wr_data = 16'hBEEF; d_wr_req = 1'b1;
    i_miss_addr = 16'h0700; i_miss_req = 1'b1;
    wait_quiet("s3", 100);
    chk("s3_writes", 32'(wr_cyc.size()), 32'd1);
    if (wr_cyc.size() == 1 && d_done_q.size() == 1 && rd_cyc.size() == 16) begin
      chk("s3_wr_addr", 32'(wr_addr_log[0]), 32'h0100);
      chk("s3_wr_data", 32'(wr_data_log[0]), 32'hBEEF);
      chk("s3_wr_after_done", 32'(wr_cyc[0] - d_done_q[0]), 32'd3);
      chk("s3_i_after_wr", 32'(rd_cyc[8] - wr_cyc[0]), 32'd3);
      chk("s3_i_base", 32'(rd_log[8]), 32'h0700);
    end else chk("s3_logs", 32'(rd_cyc.size()), 32'd16);

    // 4: reset mid-fill after 3 words
    step(); clear_logs();
    d_miss_addr = 16'h0800; d_miss_req = 1'b1;
    n = 0;
    while (d_we_cnt < 3 && n < 40) begin @(negedge clk); #1; n++; end
    chk("s4_wait_3_words", 32'(d_we_cnt), 32'd3);
    step();
    rst_n = 1'b0; d_miss_req = 1'b0;
    @(negedge clk); #1;
    chk("s4_rst_outputs", 32'({mem_en, d_fill_we, d_fill_done, busy} != 0), 32'd0);
    step();
    rst_n = 1'b1;
    wait_quiet("s4", 40);
    chk("s4_no_more_words", 32'(d_we_cnt), 32'd3);
    chk("s4_no_done", 32'(d_done_q.size()), 32'd0);

    // 6: both misses held continuously (rr pointer is D after the reset)
    step(); clear_logs();
    hold_mode = 1;
    d_miss_addr = 16'h0A00; i_miss_addr = 16'h0C00;
    d_miss_req = 1'b1; i_miss_req = 1'b1;
    n = 0;
    while (order_q.size() < 4 && n < 120) begin @(negedge clk); #1; n++; end
    step();
    d_miss_req = 1'b0; i_miss_req = 1'b0; hold_mode = 0;
    wait_quiet("s6", 40);
    chk("s6_fills", 32'(order_q.size()), 32'd4);
    if (order_q.size() == 4) begin
`ifdef MEM_ARB_RR_EN
      chk("s6_g0", 32'(order_q[0]), 32'd1);
      chk("s6_g1", 32'(order_q[1]), 32'd0);
      chk("s6_g2", 32'(order_q[2]), 32'd1);
      chk("s6_g3", 32'(order_q[3]), 32'd0);
`else
      chk("s6_g0", 32'(order_q[0]), 32'd1);
      chk("s6_g1", 32'(order_q[1]), 32'd1);
      chk("s6_g2", 32'(order_q[2]), 32'd1);
      chk("s6_g3", 32'(order_q[3]), 32'd1);
`endif
    end

    // 5: block at the top of the address space
    step(); clear_logs();
    d_miss_addr = 16'hFFFE; d_miss_req = 1'b1;
    wait_quiet("s5", 60);
    chk("s5_reads", 32'(rd_log.size()), 32'd8);
    if (rd_log.size() == 8) begin
      chk("s5_first_rd", 32'(rd_log[0]), 32'hFFF0);
      chk("s5_last_rd", 32'(rd_log[7]), 32'hFFFE);
    end
    chk("s5_done", 32'(d_done_q.size()), 32'd1);

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
